// File: rtl/mic_pkg.sv
// Shared types and constants for the mic front end: FSM states, minimum
// sample period and the mid-scale / saturation limits derived from widths.
package mic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        CALC,
        EMIT
    } state_t;

    localparam int MIN_DIV = 3;

    function automatic int mid_scale(input int width);
        return 1 << (width - 1);
    endfunction

    function automatic int sat_max(input int d_width);
        return (1 << (d_width - 1)) - 1;
    endfunction

    function automatic int sat_min(input int d_width);
        return -(1 << (d_width - 1));
    endfunction

endpackage

// File: rtl/mic_frontend_if.sv
// ADC-side handshake plus the conditioned-sample / strobe outputs that feed
// the delay line, bundled for the front end.
interface mic_frontend_if #(
    parameter int IN_WIDTH = 10,
    parameter int D_WIDTH  = 8
);
    logic                adc_valid;
    logic [IN_WIDTH-1:0] adc_data;
    logic                adc_ready;
    logic [D_WIDTH-1:0]  mic_signal;
    logic                wr;
    logic                rd;

    modport master (
        output adc_valid, adc_data,
        input  adc_ready, mic_signal, wr, rd
    );

    modport slave (
        input  adc_valid, adc_data,
        output adc_ready, mic_signal, wr, rd
    );

endinterface

// File: rtl/sample_tick.sv
// Sample-period divider: counts 0..max(div,MIN_DIV) while enabled and
// raises tick on the terminal count.
module sample_tick
    import mic_pkg::*;
#(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);
    logic [DIV_WIDTH-1:0] count;
    logic [DIV_WIDTH-1:0] limit;

    // >= lets a div shrunk below the running count wrap immediately
    always_comb begin
        limit = (div < DIV_WIDTH'(MIN_DIV)) ? DIV_WIDTH'(MIN_DIV) : div;
        tick  = en && (count >= limit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (!en || tick) begin
            count <= '0;
        end else begin
            count <= count + DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/mic_frontend.sv
// Mic front end: paces ADC samples, removes DC with a running mean and emits
// saturated offset-binary samples with one wr/rd strobe pair per sample.
module mic_frontend
    import mic_pkg::*;
#(
    parameter int IN_WIDTH  = 10,
    parameter int D_WIDTH   = 8,
    parameter int DIV_WIDTH = 16,
    parameter int AVG_SHIFT = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] div,
    mic_frontend_if.slave        mic,
    output logic                 overrun
);
    localparam int ACC_W = IN_WIDTH + AVG_SHIFT;
    localparam int SHIFT = IN_WIDTH - D_WIDTH;
    localparam logic [ACC_W-1:0]          ACC_INIT = ACC_W'(mid_scale(IN_WIDTH) << AVG_SHIFT);
    localparam logic [D_WIDTH-1:0]        MIC_INIT = D_WIDTH'(mid_scale(D_WIDTH));
    localparam logic signed [IN_WIDTH:0]  SAT_HI   = (IN_WIDTH + 1)'(sat_max(D_WIDTH));
    localparam logic signed [IN_WIDTH:0]  SAT_LO   = (IN_WIDTH + 1)'(sat_min(D_WIDTH));

    state_t                     state, state_nxt;
    logic                       tick;
    logic                       capture, update, overrun_set;
    logic [IN_WIDTH-1:0]        x_p0;
    logic [IN_WIDTH-1:0]        mean;
    logic [ACC_W-1:0]           acc;
    logic signed [IN_WIDTH:0]   diff, scaled;
    logic [D_WIDTH-1:0]         sample_p1;

    // Clamp to the signed output range, then flip the MSB into offset binary.
    function automatic logic [D_WIDTH-1:0] to_offset_binary(input logic signed [IN_WIDTH:0] v);
        logic [D_WIDTH-1:0] low;
        if (v > SAT_HI) begin
            low = SAT_HI[D_WIDTH-1:0];
        end else if (v < SAT_LO) begin
            low = SAT_LO[D_WIDTH-1:0];
        end else begin
            low = v[D_WIDTH-1:0];
        end
        return {~low[D_WIDTH-1], low[D_WIDTH-2:0]};
    endfunction

    sample_tick #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .div  (div),
        .tick (tick)
    );

    always_comb begin
        state_nxt   = state;
        capture     = 1'b0;
        update      = 1'b0;
        overrun_set = 1'b0;
        case (state)
            IDLE: if (tick) state_nxt = WAIT;
            WAIT: begin
                if (mic.adc_valid) begin
                    capture   = 1'b1;
                    state_nxt = CALC;
                end else if (tick) begin
                    overrun_set = 1'b1;
                    state_nxt   = EMIT;
                end
            end
            CALC: begin
                update      = 1'b1;
                overrun_set = tick;
                state_nxt   = EMIT;
            end
            EMIT: begin
                overrun_set = tick;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Dropping en abandons any sample in flight; acc and output hold.
        if (!en) begin
            state_nxt = IDLE;
            capture   = 1'b0;
            update    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            overrun <= 1'b0;
        end else begin
            state <= state_nxt;
            if (overrun_set) overrun <= 1'b1;
        end
    end

    // Stage p0: raw sample capture on handshake
    always_ff @(posedge clk) begin
        if (capture) x_p0 <= mic.adc_data;
    end

    always_comb begin
        mean   = acc[ACC_W-1:AVG_SHIFT];
        diff   = $signed({1'b0, x_p0}) - $signed({1'b0, mean});
        scaled = diff >>> SHIFT;
    end

    // Stage p1: DC-removed, scaled sample and tracker update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= ACC_INIT;
            sample_p1 <= MIC_INIT;
        end else if (update) begin
            acc       <= acc + ACC_W'(x_p0) - ACC_W'(mean);
            sample_p1 <= to_offset_binary(scaled);
        end
    end

    assign mic.adc_ready  = (state == WAIT);
    assign mic.wr         = (state == EMIT);
    assign mic.rd         = (state == EMIT);
    assign mic.mic_signal = sample_p1;

endmodule
